// File: rtl/program_sequencer_if.sv
// Host/core handshake bundle for program_sequencer: start/req/ack plus status and buffer readback.
interface program_sequencer_if #(
  parameter int NPROG = 3,
  parameter int CW    = 16
);
  localparam int IW = (NPROG > 1) ? $clog2(NPROG) : 1;

  logic          start;
  logic          ack;
  logic          proc_reset;
  logic          req;
  logic [IW-1:0] prog_idx;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] rd_cycles;

  modport master (
    input  start, ack, rd_idx,
    output proc_reset, req, prog_idx, busy, done, timeout, rd_cycles
  );

  modport slave (
    output start, ack, rd_idx,
    input  proc_reset, req, prog_idx, busy, done, timeout, rd_cycles
  );
endinterface

// File: rtl/program_sequencer.sv
// Resets the core, issues one req per program, times each ack into a readback buffer.
// Define SEQ_AUTO_RESET_EN to put a reset phase in front of every program, not just the first.
module program_sequencer #(
  parameter int NPROG   = 3,
  parameter int CW      = 16,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.master bus
);
  localparam int IW = (NPROG > 1) ? $clog2(NPROG) : 1;
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RST, REQ, BLANK, RUN, NEXT, DONE} state_t;

  state_t        state, state_n;
  logic [RW-1:0] rcnt;
  logic [CW-1:0] cnt, cap;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] idx;
  logic          to_flag, prst;
  logic [CW-1:0] cyc_buf [NPROG];
  logic          launch, last, to_hit;

  assign cnt_inc = cnt + 1'b1;
  assign launch  = (state == IDLE || state == DONE) && bus.start;
  assign last    = (idx == IW'(NPROG - 1));
  assign to_hit  = (cnt_inc == TO_CNT);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (bus.start) state_n = RST;
      RST:        if (rcnt == RW'(RST_CYC - 1)) state_n = REQ;
      REQ:        state_n = BLANK;
      BLANK:      state_n = RUN;
      RUN:        if (bus.ack || to_hit) state_n = NEXT;
      NEXT: begin
        if (last) state_n = DONE;
`ifdef SEQ_AUTO_RESET_EN
        else      state_n = RST;
`else
        else      state_n = REQ;
`endif
      end
      default:    state_n = IDLE;
    endcase
  end

  // proc_reset is registered from the next state so it can sit high while the host is in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      prst    <= 1'b1;
      rcnt    <= '0;
      cnt     <= '0;
      cap     <= '0;
      idx     <= '0;
      to_flag <= 1'b0;
      for (int i = 0; i < NPROG; i++) cyc_buf[i] <= '0;
    end else begin
      state <= state_n;
      prst  <= (state_n == RST);
      rcnt  <= (state == RST) ? rcnt + 1'b1 : '0;

      if (launch) begin
        idx     <= '0;
        to_flag <= 1'b0;
        cnt     <= '0;
      end

      case (state)
        REQ:   cnt <= '0;
        BLANK: cnt <= cnt_inc;
        RUN: begin
          cnt <= cnt_inc;
          // ack beats a simultaneous timeout
          if (bus.ack) cap <= cnt_inc;
          else if (to_hit) begin
            cap     <= '1;
            to_flag <= 1'b1;
          end
        end
        NEXT: begin
          cyc_buf[idx] <= cap;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.proc_reset = prst;
  assign bus.req        = (state == REQ);
  assign bus.busy       = !(state == IDLE || state == DONE);
  assign bus.done       = (state == DONE);
  assign bus.timeout    = to_flag;
  assign bus.prog_idx   = idx;
  assign bus.rd_cycles  = (32'(bus.rd_idx) < NPROG) ? cyc_buf[bus.rd_idx] : '0;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed + randomized runs of program_sequencer against a cycle-count model of the core's ack.
module tb_program_sequencer;
  localparam int NPROG = 3, CW = 16, RST_CYC = 2, TIMEOUT = 100, IW = 2;
  localparam int NEVER = 1 << 30;
`ifdef SEQ_AUTO_RESET_EN
  localparam int PHASES = NPROG;
`else
  localparam int PHASES = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_sequencer_if #(.NPROG(NPROG), .CW(CW)) bus();
  program_sequencer #(.NPROG(NPROG), .CW(CW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int tgt [NPROG];
  int c;
  logic [CW-1:0] prev_buf [NPROG];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Core model: ack rises tgt cycles after the req cycle and stays up; tgt 0 means ack stuck high.
  always @(negedge clk) begin
    if (!reset) begin
      c = 0;
      bus.ack = 1'b0;
    end else if (bus.req) begin
      c = 0;
      bus.ack = (tgt[int'(bus.prog_idx)] == 0);
    end else begin
      c++;
      bus.ack = (tgt[int'(bus.prog_idx)] == 0) || (c >= tgt[int'(bus.prog_idx)]);
    end
  end

  task automatic run(input int t0, input int t1, input int t2, input bit poke);
    int k, reqs, first_req, phases, prc, dbl;
    bit pr_prev, rq_prev, exp_to;
    logic [CW-1:0] exp [NPROG];
    tgt = '{t0, t1, t2};
    exp_to = 1'b0;
    for (int i = 0; i < NPROG; i++) begin
      if (tgt[i] <= 2) exp[i] = 2;
      else if (tgt[i] <= TIMEOUT) exp[i] = CW'(tgt[i]);
      else begin exp[i] = '1; exp_to = 1'b1; end
    end
    k = 0; reqs = 0; first_req = 0; phases = 0; prc = 0; dbl = 0;
    pr_prev = 1'b0; rq_prev = 1'b0;
    @(negedge clk) bus.start = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start = 1'b0;
        chk("done_fall", bus.done, 0);
        chk("busy_start", bus.busy, 1);
        chk("idx_clear", bus.prog_idx, 0);
        chk("timeout_clear", bus.timeout, 0);
        bus.rd_idx = IW'(2);
        #1 chk("buf_kept", bus.rd_cycles, prev_buf[2]);
      end
      if (poke && k == 20) bus.start = 1'b1;
      if (poke && k == 21) bus.start = 1'b0;
      if (bus.req) begin
        reqs++;
        if (first_req == 0) first_req = k;
        if (rq_prev) dbl++;
      end
      if (bus.proc_reset) begin
        prc++;
        if (!pr_prev) phases++;
      end
      pr_prev = bus.proc_reset;
      rq_prev = bus.req;
    end while (!bus.done && k < 3000);
    chk("done", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("req_count", reqs, NPROG);
    chk("req_single", dbl, 0);
    chk("req_latency", first_req, RST_CYC + 1);
    chk("rst_phases", phases, PHASES);
    chk("rst_cycles", prc, PHASES * RST_CYC);
    chk("timeout", bus.timeout, exp_to);
    chk("idx_last", bus.prog_idx, NPROG - 1);
    for (int i = 0; i < NPROG; i++) begin
      bus.rd_idx = IW'(i);
      #1 chk($sformatf("rd_cycles[%0d]", i), bus.rd_cycles, exp[i]);
      prev_buf[i] = exp[i];
    end
    bus.rd_idx = IW'(3);
    #1 chk("rd_oob", bus.rd_cycles, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rd_idx = '0;
    tgt = '{5, 5, 5};
    for (int i = 0; i < NPROG; i++) prev_buf[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_proc_reset", bus.proc_reset, 1);
    chk("rst_req", bus.req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_idx", bus.prog_idx, 0);
    for (int i = 0; i < NPROG; i++) begin
      bus.rd_idx = IW'(i);
      #1 chk("rst_buf", bus.rd_cycles, 0);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("rel_proc_reset", bus.proc_reset, 0);
    chk("rel_busy", bus.busy, 0);

    run(10, 25, 4, 1);
    run(5, NEVER, 7, 1);
    run(0, 1, TIMEOUT, 1);
    run(2, TIMEOUT + 1, 3, 0);
    repeat (3) run(int'($urandom_range(20, 130)), int'($urandom_range(2, 130)),
                   int'($urandom_range(2, 130)), 1);

    // Abort during program 1's RUN phase.
    tgt = '{3, NEVER, 5};
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 200 && !(bus.req && bus.prog_idx == 1); i++) @(negedge clk);
    chk("wait_prog1", bus.req && bus.prog_idx == 1, 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_proc_reset", bus.proc_reset, 1);
    chk("abort_req", bus.req, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_timeout", bus.timeout, 0);
    chk("abort_idx", bus.prog_idx, 0);
    bus.rd_idx = IW'(1);
    #1 chk("abort_buf1", bus.rd_cycles, 0);
    bus.rd_idx = IW'(0);
    #1 chk("abort_buf0", bus.rd_cycles, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("abort_rel_proc_reset", bus.proc_reset, 0);
    for (int i = 0; i < NPROG; i++) prev_buf[i] = '0;
    run(3, 4, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
